// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the dual-read data memory access controller.
package mem_access_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned MEM_DEPTH  = 64;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Request/response controller for a data memory with one write and two read ports.
// Optional MEM_ACCESS_WR_RSP_EN: stores also return a (zero-data) response.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_read_writenot,
  output logic [ADDR_W-1:0] mem_read_address1,
  output logic [ADDR_W-1:0] mem_read_address2,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data1,
  input  logic [DATA_W-1:0] mem_out_data2
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic [DATA_W-1:0] wdata_q;

  // Request direction is carried by the state itself after acceptance.
  always_comb begin
    state_d           = state_q;
    req_ready         = 1'b0;
    busy              = 1'b1;
    rsp_valid         = 1'b0;
    mem_enable        = 1'b0;
    mem_read_writenot = 1'b1;
    mem_read_address1 = '0;
    mem_read_address2 = '0;
    mem_write_address = '0;
    mem_in_data       = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = req_write ? WRITE : ISSUE;
      end
      WRITE: begin
        mem_enable        = 1'b1;
        mem_read_writenot = 1'b0;
        mem_write_address = addr1_q;
        mem_in_data       = wdata_q;
`ifdef MEM_ACCESS_WR_RSP_EN
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      ISSUE: begin
        mem_enable        = 1'b1;
        mem_read_address1 = addr1_q;
        mem_read_address2 = addr2_q;
        state_d           = CAPTURE;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr1_q   <= '0;
      addr2_q   <= '0;
      wdata_q   <= '0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr1_q <= req_addr1;
        addr2_q <= req_addr2;
        wdata_q <= req_wdata;
      end
      if (state_q == CAPTURE) begin
        rsp_data1 <= mem_out_data1;
        rsp_data2 <= mem_out_data2;
      end
`ifdef MEM_ACCESS_WR_RSP_EN
      if (state_q == WRITE) begin
        rsp_data1 <= '0;
        rsp_data2 <= '0;
      end
`endif
    end
  end

endmodule
